// File: rtl/dmix_rate_detect_if.sv
// Audio-side signal bundle for the lrck rate detector: the incoming word clock
// plus the detected rate, lock flag, raw period and change strobe.
interface dmix_rate_detect_if;
    logic        lrck;
    logic [1:0]  rate;
    logic        locked;
    logic [11:0] period;
    logic        rate_change;

    // Source side: drives lrck and observes the detector results.
    modport master (
        output lrck,
        input  rate,
        input  locked,
        input  period,
        input  rate_change
    );

    // Detector side: samples lrck and drives the results.
    modport slave (
        input  lrck,
        output rate,
        output locked,
        output period,
        output rate_change
    );
endinterface

// File: rtl/dmix_rate_detect.sv
// LRCK sample-rate detector. Measures the period of an asynchronous word clock
// in clk983040 cycles, classifies it as 48/96/192 kHz and only reports a rate
// after LOCK_COUNT consecutive measurements of the same class. Loss of lrck
// (counter saturating) drops the lock and returns to waiting for an edge.
module dmix_rate_detect #(
    parameter int LOCK_COUNT = 4
) (
    input  logic            clk983040,
    input  logic            rst_n,
    dmix_rate_detect_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]  LOCK_CNT_C = 4'(LOCK_COUNT);
    localparam logic [11:0] CNT_MAX_C  = 12'd4095;

    // Map a measured period onto a rate code; anything outside the windows is 0.
    function automatic logic [1:0] classify(input logic [11:0] p);
        logic [1:0] cls;
        cls = 2'd0;
        if ((p >= 12'd1920) && (p <= 12'd2175)) begin
            cls = 2'd1;
        end else if ((p >= 12'd960) && (p <= 12'd1087)) begin
            cls = 2'd2;
        end else if ((p >= 12'd480) && (p <= 12'd543)) begin
            cls = 2'd3;
        end else begin
            cls = 2'd0;
        end
        return cls;
    endfunction

    logic        lrck_meta_r;
    logic        lrck_sync_r;
    logic        lrck_prev_r;
    logic [1:0]  guard_r;
    logic        edge_s;

    logic [11:0] cnt_r;

    state_t      state_r,  state_s;
    logic [1:0]  cand_r,   cand_s;
    logic [3:0]  match_r,  match_s;
    logic [1:0]  rate_r,   rate_s;
    logic        locked_r, locked_s;
    logic        rc_r,     rc_s;
    logic [11:0] period_r, period_s;
    logic [1:0]  meas_cls_s;
    logic        timeout_s;

    // Two-flop synchroniser, edge-detect stage and post-reset edge guard.
    always_ff @(posedge clk983040 or negedge rst_n) begin
        if (!rst_n) begin
            lrck_meta_r <= 1'b0;
            lrck_sync_r <= 1'b0;
            lrck_prev_r <= 1'b0;
            guard_r     <= 2'd0;
        end else begin
            lrck_meta_r <= bus.lrck;
            lrck_sync_r <= lrck_meta_r;
            lrck_prev_r <= lrck_sync_r;
            if (guard_r != 2'd3) begin
                guard_r <= guard_r + 2'd1;
            end else begin
                guard_r <= guard_r;
            end
        end
    end

    // Rising edges are ignored until the guard has seen three clean cycles,
    // so an lrck that is already high at reset release cannot fake an edge.
    assign edge_s = lrck_sync_r & ~lrck_prev_r & (guard_r == 2'd3);

    // Period counter: restarts at 1 on every edge, saturates to flag lost lrck.
    always_ff @(posedge clk983040 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 12'd0;
        end else if (edge_s) begin
            cnt_r <= 12'd1;
        end else if (cnt_r != CNT_MAX_C) begin
            cnt_r <= cnt_r + 12'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Detector state and registered outputs.
    always_ff @(posedge clk983040 or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cand_r   <= 2'd0;
            match_r  <= 4'd0;
            rate_r   <= 2'd0;
            locked_r <= 1'b0;
            rc_r     <= 1'b0;
            period_r <= 12'd0;
        end else begin
            state_r  <= state_s;
            cand_r   <= cand_s;
            match_r  <= match_s;
            rate_r   <= rate_s;
            locked_r <= locked_s;
            rc_r     <= rc_s;
            period_r <= period_s;
        end
    end

    // Next-state logic: arm, accumulate matching measurements, lock, drop out.
    always_comb begin
        state_s    = state_r;
        cand_s     = cand_r;
        match_s    = match_r;
        rate_s     = rate_r;
        locked_s   = locked_r;
        rc_s       = 1'b0;
        period_s   = period_r;
        meas_cls_s = classify(cnt_r);
        timeout_s  = (cnt_r == CNT_MAX_C);

        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    // First edge only gives the counter a reference point.
                    state_s = ST_ACQUIRE;
                    cand_s  = 2'd0;
                    match_s = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACQUIRE, ST_LOCKED: begin
                if (timeout_s) begin
                    // A saturated counter wins over a coincident edge.
                    state_s  = ST_IDLE;
                    cand_s   = 2'd0;
                    match_s  = 4'd0;
                    rate_s   = 2'd0;
                    locked_s = 1'b0;
                    rc_s     = (rate_r != 2'd0);
                end else if (edge_s) begin
                    period_s = cnt_r;
                    if (state_r == ST_LOCKED) begin
                        if (meas_cls_s == rate_r) begin
                            state_s = ST_LOCKED;
                        end else begin
                            state_s  = ST_ACQUIRE;
                            cand_s   = meas_cls_s;
                            match_s  = (meas_cls_s != 2'd0) ? 4'd1 : 4'd0;
                            rate_s   = 2'd0;
                            locked_s = 1'b0;
                            rc_s     = 1'b1;
                        end
                    end else begin
                        if (meas_cls_s == 2'd0) begin
                            cand_s  = 2'd0;
                            match_s = 4'd0;
                        end else if (meas_cls_s == cand_r) begin
                            if ((match_r + 4'd1) == LOCK_CNT_C) begin
                                state_s  = ST_LOCKED;
                                match_s  = match_r + 4'd1;
                                rate_s   = cand_r;
                                locked_s = 1'b1;
                                rc_s     = 1'b1;
                            end else begin
                                match_s = match_r + 4'd1;
                            end
                        end else begin
                            cand_s  = meas_cls_s;
                            match_s = 4'd1;
                        end
                    end
                end else begin
                    state_s = state_r;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                cand_s   = 2'd0;
                match_s  = 4'd0;
                rate_s   = 2'd0;
                locked_s = 1'b0;
            end
        endcase
    end

    assign bus.rate        = rate_r;
    assign bus.locked      = locked_r;
    assign bus.period      = period_r;
    assign bus.rate_change = rc_r;

endmodule

// File: doc/dmix_rate_detect.md
DMIX_RATE_DETECT -- requirements
Module: dmix_rate_detect

Interface
REQ-001 Parameter: LOCK_COUNT, 4, number of consecutive same-class measurements needed to lock (range 2..15).
REQ-002 Port: clk983040  input  1  98.304 MHz system clock; all state in this domain.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: lrck  input  1  asynchronous audio word clock from external source.
REQ-005 Port: rate  output  2  detected rate: 0 none, 1 = 48 kHz, 2 = 96 kHz, 3 = 192 kHz.
REQ-006 Port: locked  output  1  high while rate is valid and stable.
REQ-007 Port: period  output  12  last measured lrck period, in clk983040 cycles.
REQ-008 Port: rate_change  output  1  one-cycle strobe whenever rate changes value.

Function
REQ-009 The block SHALL synchronise lrck through two flops, then register once more for edge detection; a rising-edge strobe is produced 3 cycles after the sampled transition.
REQ-010 The block SHALL keep a 12-bit cycle counter: set to 1 on each edge strobe, +1 otherwise, saturating at 4095.
REQ-011 On an edge strobe the block SHALL take the counter value as the measurement P and load it into period the next cycle.
REQ-012 Classification of P SHALL be: 1920..2175 -> 48k, 960..1087 -> 96k, 480..543 -> 192k, else invalid (0).
REQ-013 States SHALL be IDLE (no reference edge), ACQUIRE (candidate class plus 4-bit match count), LOCKED.
REQ-014 IDLE: the first edge strobe SHALL only arm the counter and move to ACQUIRE with candidate 0 and match count 0; no measurement is made.
REQ-015 ACQUIRE: valid P with class == candidate SHALL increment the match count; on reaching LOCK_COUNT the block SHALL go to LOCKED, set rate = candidate, set locked = 1 and pulse rate_change.
REQ-016 ACQUIRE: P with a different class SHALL set candidate = class, with match count = 1 if the class is valid, else 0.
REQ-017 LOCKED: P with class == rate SHALL keep the block in LOCKED with no strobe.
REQ-018 LOCKED: P with a different class SHALL move to ACQUIRE with candidate = new class and match count = 1 (0 if invalid); rate SHALL go to 0, locked to 0, and rate_change SHALL pulse.
REQ-019 Timeout: when the counter reaches 4095 in ACQUIRE or LOCKED, the block SHALL go to IDLE with rate = 0 and locked = 0, and SHALL pulse rate_change only if rate was nonzero.
REQ-020 An edge strobe coincident with counter = 4095 SHALL be treated as a timeout, not as a measurement.
REQ-021 rate, locked and rate_change SHALL be registered outputs, updated in the cycle after the deciding edge strobe or timeout.
REQ-022 rate_change SHALL never be high for two consecutive cycles.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state IDLE, counter 0, synchroniser flops 0, period 0, rate 0, locked 0 and rate_change 0.
REQ-024 Reset mid-measurement SHALL discard all partial counts; after release, lock SHALL require a fresh arming edge plus LOCK_COUNT full measurements.
REQ-025 Deassertion is asynchronous; the block SHALL ignore lrck edges sampled within the first 3 cycles after release.

Verification
REQ-026 Bench: lrck period 2048 cycles, LOCK_COUNT = 4 -> locked = 1 and rate = 1 after the 5th rising edge; period = 2048; exactly one rate_change strobe.
REQ-027 Bench: lock at 512 cycles (rate 3), then switch to 1024 -> rate = 0 and locked = 0 on the first 1024 measurement with a strobe; after 4 measurements rate = 2 with a second strobe.
REQ-028 Bench: while locked at 48k, stop lrck -> rate = 0 and locked = 0 when the counter hits 4095, one strobe; restarting lrck at 2048 relocks after 5 edges.
REQ-029 Bench: alternate periods of 2048 and 1500 -> never locked; rate stays 0; period tracks each value.
REQ-030 Bench: boundary periods 1919, 1920, 2175 and 2176, each repeated -> only 1920 and 2175 lock to rate 1.
REQ-031 Bench: assert rst_n during the 3rd measurement of an acquisition -> all outputs are 0 at once; after release, lock occurs on the 5th post-reset edge.
